// File: rtl/alu_preprocess_q_if.sv
// Handshake bus for the ALU operand preprocessor: the operand/opcode input
// stream plus the decoded-operand output stream and the occupancy count.
interface alu_preprocess_q_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] AMod;
    logic [WIDTH-1:0] BMod;
    logic             Cin;
    logic [3:0]       OpOut;
    logic [CNT_W-1:0] count;

    // Source/consumer side (testbench or surrounding pipeline)
    modport master (
        output in_valid, A, B, Op, out_ready,
        input  in_ready, out_valid, AMod, BMod, Cin, OpOut, count
    );

    // Preprocessor side
    modport slave (
        input  in_valid, A, B, Op, out_ready,
        output in_ready, out_valid, AMod, BMod, Cin, OpOut, count
    );
endinterface

// File: rtl/alu_preprocess_q.sv
// Registered ALU operand preprocessor: decodes Op into adder operands
// AMod/BMod and carry-in Cin, then buffers the result in a DEPTH-entry FIFO
// with valid/ready handshakes on both sides.
module alu_preprocess_q #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_preprocess_q_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * WIDTH + 5;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = '1;

    // Entry layout: {OpOut, Cin, BMod, AMod}
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] amod_dec, bmod_dec;
    logic             cin_dec;
    logic             push, pop, full, empty;
    logic [ENT_W-1:0] head;

    // Opcode decode into adder operands; pass-through is the default
    always_comb begin
        amod_dec = bus.A;
        bmod_dec = bus.B;
        cin_dec  = 1'b0;
        casez (bus.Op)
            4'b0000: begin amod_dec = ZERO; bmod_dec = bus.A;             end
            4'b0001: begin amod_dec = ONE;  bmod_dec = ~bus.A;            end
            4'b0010: begin amod_dec = bus.A; bmod_dec = bus.B;            end
            4'b0011: begin amod_dec = ONE;  bmod_dec = bus.A;             end
            4'b01??: begin amod_dec = bus.A; bmod_dec = bus.B;            end
            4'b1000: begin amod_dec = bus.A; bmod_dec = ~bus.B; cin_dec = 1'b1; end
            4'b1001: begin amod_dec = bus.A; bmod_dec = ONES;             end
            4'b1010: begin amod_dec = bus.B; bmod_dec = ~bus.A; cin_dec = 1'b1; end
            4'b1011: begin amod_dec = ZERO; bmod_dec = ~bus.B; cin_dec = 1'b1; end
            default: begin amod_dec = bus.A; bmod_dec = bus.B;            end
        endcase
    end

    // No bypass when full: a pop while full only frees space next cycle
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign bus.in_ready = !full && !reset;
    assign bus.out_valid = !empty;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_valid && bus.out_ready;

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous reset; discards all buffered entries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written only on push and never modified afterwards
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.Op, cin_dec, bmod_dec, amod_dec};
    end

    // Head entry drives the outputs; forced to zero when the FIFO is empty
    assign head      = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.AMod  = head[WIDTH-1:0];
    assign bus.BMod  = head[2*WIDTH-1:WIDTH];
    assign bus.Cin   = head[2*WIDTH];
    assign bus.OpOut = head[ENT_W-1 -: 4];
    assign bus.count = count_q;
endmodule

// File: tb/tb_alu_preprocess_q.sv
// Testbench for alu_preprocess_q (WIDTH=8, DEPTH=4) with a queue-based
// reference model and arithmetic operand decode.
module tb_alu_preprocess_q;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 2 + CW + 2 * W + 5;

    typedef struct packed {
        logic [W-1:0] amod;
        logic [W-1:0] bmod;
        logic         cin;
        logic [3:0]   op;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    entry_t q[$];

    always #5 clk = ~clk;

    alu_preprocess_q_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();
    alu_preprocess_q #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference decode expressed as plain integer arithmetic
    function automatic entry_t ref_decode(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned mask = (1 << W) - 1;
        int unsigned av = a, bv = b, am, bm;
        entry_t e;
        bit c = 0;
        case (op) inside
            4'd0:  begin am = 0;  bm = av;        end
            4'd1:  begin am = 1;  bm = mask - av; end
            4'd2:  begin am = av; bm = bv;        end
            4'd3:  begin am = 1;  bm = av;        end
            4'd8:  begin am = av; bm = mask - bv; c = 1; end
            4'd9:  begin am = av; bm = mask;      end
            4'd10: begin am = bv; bm = mask - av; c = 1; end
            4'd11: begin am = 0;  bm = mask - bv; c = 1; end
            default: begin am = av; bm = bv;      end
        endcase
        e.amod = W'(am);
        e.bmod = W'(bm);
        e.cin  = c;
        e.op   = op;
        return e;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        entry_t h = (q.size() != 0) ? q[0] : '0;
        return {q.size() != 0, q.size() != DEPTH, CW'(q.size()), h.amod, h.bmod, h.cin, h.op};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.out_valid, bus.in_ready, bus.count, bus.AMod, bus.BMod, bus.Cin, bus.OpOut};
    endfunction

    // Advance one clock; model applies the handshake it predicts
    task automatic tick();
        bit     push = bus.in_valid && (q.size() != DEPTH);
        bit     pop  = (q.size() != 0) && bus.out_ready;
        entry_t e    = ref_decode(bus.Op, bus.A, bus.B);
        @(posedge clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = v;
        bus.Op = op;
        bus.A  = a;
        bus.B  = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, '0, '0);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got=%h required=%h", dut_vec(), {VW{1'b0}});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.count !== '0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b count=%0d required in_ready=1 count=0", bus.in_ready, bus.count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'b0010, 8'h35, 8'h12);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++;
        if ({bus.out_valid, bus.AMod, bus.BMod, bus.Cin, bus.OpOut} !== {1'b1, 8'h35, 8'h12, 1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL single_push: got v=%b A=%h B=%h c=%b op=%b required v=1 A=35 B=12 c=0 op=0010",
                     bus.out_valid, bus.AMod, bus.BMod, bus.Cin, bus.OpOut);
        end
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec() || bus.count !== '0 || bus.AMod !== '0 || bus.BMod !== '0) begin
            n_fail++;
            $display("FAIL single_drain: got=%h required=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_order();
        logic [2*W:0] want [3];
        want[0] = {8'h01, 8'hFA, 1'b0};
        want[1] = {8'h10, 8'hFC, 1'b1};
        want[2] = {8'h01, 8'hFF, 1'b0};
        bus.out_ready = 1'b0;
        drive(1'b1, 4'b0001, 8'h05, 8'h00); tick();
        drive(1'b1, 4'b1000, 8'h10, 8'h03); tick();
        drive(1'b1, 4'b0011, 8'hFF, 8'h00); tick();
        drive(1'b0, 4'd0, '0, '0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.AMod, bus.BMod, bus.Cin} !== want[i] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL order_head%0d: got A=%h B=%h c=%b v=%b required %h",
                         i, bus.AMod, bus.BMod, bus.Cin, bus.out_valid, want[i]);
            end
            tick();
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL order_empty: got=%h required=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 4'b0000, W'(i), 8'hAA);
            n_checks++;
            if (bus.in_ready !== (i <= 4)) begin
                n_fail++;
                $display("FAIL full_in_ready%0d: got=%b required=%b", i, bus.in_ready, (i <= 4));
            end
            tick();
        end
        drive(1'b0, 4'd0, '0, '0);
        n_checks++;
        if (bus.count !== CW'(4)) begin
            n_fail++;
            $display("FAIL full_count: got=%0d required=4", bus.count);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (bus.BMod !== W'(i) || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL full_drain%0d: got BMod=%h v=%b required BMod=%h v=1", i, bus.BMod, bus.out_valid, W'(i));
            end
            tick();
        end
        n_checks++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty: got count=%0d v=%b required 0/0", bus.count, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec() || bus.count !== CW'(2)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got=%h required=%h", i, dut_vec(), exp_vec());
            end
        end
        drive(1'b0, 4'd0, '0, '0);
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got=%h required=%h", i, dut_vec(), exp_vec());
            end
        end
        drive(1'b0, 4'd0, '0, '0);
        bus.out_ready = 1'b1;
        for (int i = 0; i <= DEPTH && q.size() != 0; i++) tick();
    endtask

    task automatic test_full_pushpop();
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            tick();
        end
        drive(1'b1, 4'b0010, 8'h77, 8'h66);
        bus.out_ready = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fullpp_block: got in_ready=%b count=%0d required 0/%0d", bus.in_ready, bus.count, DEPTH);
        end
        tick();
        drive(1'b0, 4'd0, '0, '0);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.count !== CW'(3) || bus.in_ready !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fullpp_after: got=%h required=%h (count=%0d in_ready=%b)",
                     dut_vec(), exp_vec(), bus.count, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        n_checks++;
        if ({bus.out_valid, bus.count, bus.AMod, bus.BMod, bus.Cin, bus.in_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b count=%0d A=%h B=%h c=%b rdy=%b required all 0",
                     bus.out_valid, bus.count, bus.AMod, bus.BMod, bus.Cin, bus.in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 4'b1011, 8'h00, 8'h01);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++;
        if ({bus.out_valid, bus.AMod, bus.BMod, bus.Cin} !== {1'b1, 8'h00, 8'hFE, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_repush: got v=%b A=%h B=%h c=%b required v=1 A=00 B=fe c=1",
                     bus.out_valid, bus.AMod, bus.BMod, bus.Cin);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_full();
        test_back_to_back();
        test_random();
        test_full_pushpop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_preprocess_q.md
Name: alu_preprocess_q

Overview:
- Parametrised, registered successor of the ALU operand preprocessor.
- Decodes a 4-bit opcode into modified adder operands AMod/BMod plus an explicit carry-in Cin, for any WIDTH.
- Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between the instruction/operand source and the adder/ALU core, decoupling their timing.

Parameters:
- WIDTH, 4, operand width in bits (>=2).
- DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B/Op valid this cycle.
- in_ready  output  1  block accepts an entry this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Op  input  4  operation code.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry.
- AMod  output  WIDTH  modified operand 1.
- BMod  output  WIDTH  modified operand 2.
- Cin  output  1  adder carry-in.
- OpOut  output  4  opcode travelling with the entry.
- count  output  $clog2(DEPTH)+1  current number of occupied entries.

Behaviour:
- Decode, combinational on the inputs, stored at push. Z = all zeros, ONE = 1 zero-extended, ~X = bitwise complement.
  - 0000: AMod=Z, BMod=A, Cin=0 (transfer A).
  - 0001: AMod=ONE, BMod=~A, Cin=0 (negate A).
  - 0010: AMod=A, BMod=B, Cin=0 (A+B).
  - 0011: AMod=ONE, BMod=A, Cin=0 (A+1).
  - 01xx: AMod=A, BMod=B, Cin=0 (logic ops, pass-through).
  - 1000: AMod=A, BMod=~B, Cin=1 (A-B).
  - 1001: AMod=A, BMod=all ones, Cin=0 (A-1).
  - 1010: AMod=B, BMod=~A, Cin=1 (B-A).
  - 1011: AMod=Z, BMod=~B, Cin=1 (negate B).
  - 11xx: AMod=A, BMod=B, Cin=0.
- All results are exactly WIDTH bits; no arithmetic is performed here, so there is no overflow or carry-out.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count != DEPTH) and not in reset. There is no same-cycle bypass when full: a pop while full frees space for the next cycle only.
- out_valid = (count != 0).
- AMod/BMod/Cin/OpOut show the head entry. They are driven to zero when empty.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N, i.e. one cycle. Empty-FIFO throughput is 1 entry/cycle with out_ready held high.
- Pointers wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
- count updates:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
  - neither: hold.
- Ordering is strict FIFO. Entry contents never change after push.
- Input stalls: in_valid with in_ready=0 is ignored. The source holds its data; the block does not latch it.
- Output stalls: out_ready=0 holds the head entry and its outputs stable.
- Reset (asynchronous, any time, including mid-stream):
  - Immediately: count=0, pointers=0, out_valid=0, AMod/BMod/OpOut=0, Cin=0, in_ready=0.
  - FIFO contents are discarded.
  - in_ready rises in the first cycle after reset deasserts.
- Storage contents need not be reset; only pointers and count.

Test Plan:
- WIDTH=8, DEPTH=4. Push Op=0010, A=0x35, B=0x12 with out_ready=1 -> next cycle out_valid=1, AMod=0x35, BMod=0x12, Cin=0, OpOut=0010; the cycle after, count=0 and outputs are 0.
- Push Op=0001, A=0x05, then Op=1000, A=0x10, B=0x03, then Op=0011, A=0xFF -> heads appear in order:
  - first: AMod=0x01, BMod=0xFA, Cin=0.
  - second: AMod=0x10, BMod=0xFC, Cin=1.
  - third: AMod=0x01, BMod=0xFF, Cin=0.
- out_ready=0, in_valid=1 for 6 cycles with A=1..6 -> in_ready falls after 4 accepts, count=4, A=5/6 not stored. Then out_ready=1 -> A=1,2,3,4 drained in order and count returns to 0.
- count=2, push and pop in the same cycle -> count stays 2, head advances. Run 10 such cycles to confirm pointer wrap with correct order.
- Full FIFO, pop and push asserted together -> only the pop takes effect (in_ready=0), count=3, and in_ready=1 the next cycle.
- count=3 with out_valid=1, assert reset mid-cycle -> out_valid, count, AMod, BMod and Cin go to 0 without a clock edge. After deassertion a fresh push of Op=1011, B=0x01 yields AMod=0x00, BMod=0xFE, Cin=1.
